// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, shared-ALU and response signals of alu_arbiter
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_id;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, alu_result, resp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_control,
           resp_valid, resp_data, resp_id
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, alu_result, resp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_control,
           resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Optional grant counters gnt_cnt0/gnt_cnt1 are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            r_state;
  logic              r_last;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic              r_id;
  logic              r_valid;
  logic              w_idle;
  logic              w_gnt0;
  logic              w_gnt1;

  // Gated by rst_n so the readies are forced low while reset is held.
  assign w_idle = rst_n && (r_state == IDLE);
  assign w_gnt0 = w_idle && bus.req0_valid && (!bus.req1_valid || r_last);
  assign w_gnt1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_id    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_a     <= w_gnt1 ? bus.req1_a    : bus.req0_a;
            r_b     <= w_gnt1 ? bus.req1_b    : bus.req0_b;
            r_ctrl  <= w_gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_data  <= bus.alu_result;
          r_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready  = w_gnt0;
  assign bus.req1_ready  = w_gnt1;
  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_control = r_ctrl;
  assign bus.resp_valid  = r_valid;
  assign bus.resp_data   = r_data;
  assign bus.resp_id     = r_id;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_gnt0 && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_gnt1 && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign gnt_cnt0 = r_cnt0;
  assign gnt_cnt1 = r_cnt1;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand and result width in bits.
REQ-002 The block SHALL have parameter CTRL_W, default 4, ALU control code width in bits.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1 each  requester n has an operation pending.
REQ-006 The block SHALL have ports req0_ready / req1_ready  output  1 each  requester n's operation accepted this cycle.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_W each  operands.
REQ-008 The block SHALL have ports req0_ctrl / req1_ctrl  input  CTRL_W each  ALU control code (0000 AND, 0001 OR, 0010 ADD).
REQ-009 The block SHALL have ports alu_a, alu_b  output  DATA_W each, and alu_control  output  CTRL_W  to the shared ALU.
REQ-010 The block SHALL have port alu_result  input  DATA_W  combinational result from the shared ALU.
REQ-011 The block SHALL have port resp_valid  output  1  response available.
REQ-012 The block SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-013 The block SHALL have port resp_data  output  DATA_W  registered ALU result.
REQ-014 The block SHALL have port resp_id  output  1  requester index (0/1) the response belongs to.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP; exactly one operation is in flight at a time.
REQ-016 In IDLE, a grant SHALL occur when any reqN_valid=1; only the granted reqN_ready SHALL be 1, combinationally, in that cycle; the FSM then moves to EXEC.
REQ-017 Arbitration SHALL be round-robin: a lone request always wins; on a tie, the requester not granted last wins.
REQ-018 At grant, the block SHALL latch the granted operands, control code and index into registers driving alu_a, alu_b, alu_control and resp_id.
REQ-019 In EXEC, the block SHALL capture alu_result into resp_data at the clock edge and move to RESP.
REQ-020 In RESP, resp_valid SHALL be 1, and resp_data and resp_id SHALL be stable until resp_ready=1; the FSM then returns to IDLE.
REQ-021 Latency SHALL be: grant at edge N, resp_valid high from edge N+2; minimum spacing between grants is 3 cycles with resp_ready held at 1.
REQ-022 reqN_ready SHALL be 0 in EXEC and RESP; requesters hold valid and payload stable until ready.
REQ-023 Widths SHALL be unchanged: resp_data is exactly the DATA_W-bit alu_result, with no carry-out or sign extension added.
REQ-024 A requester that drops valid before its grant SHALL be ignored without any state change.

Reset
REQ-025 Asserting rst_n=0 SHALL, asynchronously, set the state to IDLE and drive resp_valid, reqN_ready, alu_a, alu_b, alu_control, resp_data and resp_id to 0, and set the last-grant pointer to 1 so that req0 wins the first tie.
REQ-026 Reset during EXEC or RESP SHALL discard the in-flight operation, with no response ever issued for it.

Configuration
REQ-027 With macro ALU_ARB_STATS_EN defined, the block SHALL add output ports gnt_cnt0 and gnt_cnt1 (16 bits each), reset to 0, each incrementing on its requester's grant and saturating at 16'hFFFF.
REQ-028 Without ALU_ARB_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario: req0 only, a=FFFF0000, b=00FFFF00, ctrl=0000, resp_ready=1 -> req0_ready for 1 cycle, resp_valid 2 cycles later, resp_data=00FF0000, resp_id=0.
REQ-030 Scenario: req0 and req1 both valid from reset, req0 OR (FFFF0000|00FFFF00), req1 AND of the same operands -> first response id=0 with data FFFFFF00, second id=1 with data 00FF0000.
REQ-031 Scenario: both requesters held valid for 6 grants -> grant order 0,1,0,1,0,1.
REQ-032 Scenario: resp_ready=0 for 5 cycles during RESP -> resp_valid and resp_data stable, both reqN_ready=0, completion on the first resp_ready=1 cycle.
REQ-033 Scenario: rst_n pulsed low in EXEC -> outputs 0 immediately, no response issued, next request serviced normally.
REQ-034 Scenario: with ALU_ARB_STATS_EN defined, 3 grants to req0 and 2 to req1 -> gnt_cnt0=3, gnt_cnt1=2.
